// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - raster timing bundle between the timing source and the pixel generators
interface video_timing_gen_if;
  logic        i_en;
  logic [11:0] o_cnt_x;
  logic [11:0] o_cnt_y;
  logic        o_active;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_de;
  logic        o_line_start;
  logic        o_frame_start;
  logic [15:0] o_frame_cnt;

  modport master (
    input  i_en,
    output o_cnt_x, o_cnt_y, o_active, o_hsync, o_vsync, o_de,
    output o_line_start, o_frame_start, o_frame_cnt
  );

  modport slave (
    output i_en,
    input  o_cnt_x, o_cnt_y, o_active, o_hsync, o_vsync, o_de,
    input  o_line_start, o_frame_start, o_frame_cnt
  );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - free-running raster counter with delayed hsync/vsync/de
// Sync and de are delayed so they line up with the registered RGB of downstream generators.
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int SYNC_DLY = 1
) (
  input  logic               i_pixclk,
  input  logic               i_reset_n,
  video_timing_gen_if.master vt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 4096 || V_TOTAL > 4096 || SYNC_DLY > 7 || SYNC_DLY < 0) begin : g_bad_params
      $error("video_timing_gen: totals must be <= 4096 and SYNC_DLY within 0..7");
    end
  endgenerate

  localparam logic [11:0] X_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] Y_LAST   = 12'(V_TOTAL - 1);
  localparam logic [12:0] X_ACT    = 13'(H_ACTIVE);
  localparam logic [12:0] Y_ACT    = 13'(V_ACTIVE);
  localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [11:0] cnt_x;
  logic [11:0] cnt_y;
  logic [15:0] frame_cnt;
  logic        line_start;
  logic        frame_start;

  always_ff @(posedge i_pixclk) begin
    if (!i_reset_n) begin
      cnt_x       <= '0;
      cnt_y       <= '0;
      frame_cnt   <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (vt.i_en) begin
        if (cnt_x != X_LAST) begin
          cnt_x <= cnt_x + 12'd1;
        end else begin
          cnt_x      <= '0;
          line_start <= 1'b1;
          if (cnt_y != Y_LAST) begin
            cnt_y <= cnt_y + 12'd1;
          end else begin
            cnt_y       <= '0;
            frame_start <= 1'b1;
            frame_cnt   <= frame_cnt + 16'd1;
          end
        end
      end
    end
  end

  // Raw decode in asserted-sense; polarity is applied only at the outputs.
  logic active;
  logic hs_on;
  logic vs_on;

  assign active = ({1'b0, cnt_x} < X_ACT) && ({1'b0, cnt_y} < Y_ACT);
  assign hs_on  = ({1'b0, cnt_x} >= HS_START) && ({1'b0, cnt_x} <= HS_END);
  assign vs_on  = ({1'b0, cnt_y} >= VS_START) && ({1'b0, cnt_y} <= VS_END);

  logic hs_q;
  logic vs_q;
  logic de_q;

  generate
    if (SYNC_DLY == 0) begin : g_nodly
      assign hs_q = hs_on;
      assign vs_q = vs_on;
      assign de_q = active;
    end else begin : g_dly
      logic [SYNC_DLY-1:0] hs_pipe;
      logic [SYNC_DLY-1:0] vs_pipe;
      logic [SYNC_DLY-1:0] de_pipe;

      // Shifts every clock regardless of i_en so the delay stays fixed in clocks.
      always_ff @(posedge i_pixclk) begin
        if (!i_reset_n) begin
          hs_pipe <= '0;
          vs_pipe <= '0;
          de_pipe <= '0;
        end else begin
          hs_pipe[0] <= hs_on;
          vs_pipe[0] <= vs_on;
          de_pipe[0] <= active;
          for (int i = 1; i < SYNC_DLY; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
            de_pipe[i] <= de_pipe[i-1];
          end
        end
      end

      assign hs_q = hs_pipe[SYNC_DLY-1];
      assign vs_q = vs_pipe[SYNC_DLY-1];
      assign de_q = de_pipe[SYNC_DLY-1];
    end
  endgenerate

  assign vt.o_cnt_x       = cnt_x;
  assign vt.o_cnt_y       = cnt_y;
  assign vt.o_active      = active;
  assign vt.o_hsync       = hs_q ? H_POL : ~H_POL;
  assign vt.o_vsync       = vs_q ? V_POL : ~V_POL;
  assign vt.o_de          = de_q;
  assign vt.o_line_start  = line_start;
  assign vt.o_frame_start = frame_start;
  assign vt.o_frame_cnt   = frame_cnt;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench: 720p defaults and a reduced low-polarity raster
`timescale 1ns/1ps
module tb_video_timing_gen;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    bit hp; bit vp;
    int dly;
  } cfg_t;

  typedef struct packed {
    int x; int y; int fc;
    bit ls; bit fs;
    bit [7:0] hpipe; bit [7:0] vpipe; bit [7:0] apipe;
  } st_t;

  typedef struct packed {
    logic [11:0] x; logic [11:0] y;
    logic act; logic hs; logic vs; logic de; logic ls; logic fs;
    logic [15:0] fc;
  } exp_t;

  localparam cfg_t CFG_A = '{ha:1280, hf:110, hs:40, hb:220, va:720, vf:5, vs:5, vb:20,
                             hp:1'b1, vp:1'b1, dly:1};
  localparam cfg_t CFG_B = '{ha:8, hf:2, hs:2, hb:2, va:4, vf:1, vs:1, vb:1,
                             hp:1'b0, vp:1'b0, dly:3};

  logic clk;
  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;

  video_timing_gen_if vif_a();
  video_timing_gen_if vif_b();

  video_timing_gen dut_a (.i_pixclk(clk), .i_reset_n(rst_a), .vt(vif_a));

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .SYNC_DLY(3)
  ) dut_b (.i_pixclk(clk), .i_reset_n(rst_b), .vt(vif_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic bit f_act(cfg_t c, int x, int y);
    return (x < c.ha) && (y < c.va);
  endfunction
  function automatic bit f_hs(cfg_t c, int x);
    return (x >= c.ha + c.hf) && (x < c.ha + c.hf + c.hs);
  endfunction
  function automatic bit f_vs(cfg_t c, int y);
    return (y >= c.va + c.vf) && (y < c.va + c.vf + c.vs);
  endfunction

  function automatic st_t step(st_t m, cfg_t c, bit rstn, bit en);
    st_t n;
    int ht, vt;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    n = '0;
    if (!rstn) return n;
    n = m;
    n.hpipe = {m.hpipe[6:0], f_hs(c, m.x)};
    n.vpipe = {m.vpipe[6:0], f_vs(c, m.y)};
    n.apipe = {m.apipe[6:0], f_act(c, m.x, m.y)};
    n.ls = 1'b0;
    n.fs = 1'b0;
    if (en) begin
      if (m.x < ht - 1) n.x = m.x + 1;
      else begin
        n.x = 0; n.ls = 1'b1;
        if (m.y < vt - 1) n.y = m.y + 1;
        else begin
          n.y = 0; n.fs = 1'b1; n.fc = (m.fc + 1) % 65536;
        end
      end
    end
    return n;
  endfunction

  function automatic exp_t outs(st_t m, cfg_t c);
    exp_t e;
    bit h, v, d;
    h = (c.dly == 0) ? f_hs(c, m.x)       : m.hpipe[c.dly-1];
    v = (c.dly == 0) ? f_vs(c, m.y)       : m.vpipe[c.dly-1];
    d = (c.dly == 0) ? f_act(c, m.x, m.y) : m.apipe[c.dly-1];
    e.x   = 12'(m.x);
    e.y   = 12'(m.y);
    e.act = f_act(c, m.x, m.y);
    e.hs  = h ? c.hp : ~c.hp;
    e.vs  = v ? c.vp : ~c.vp;
    e.de  = d;
    e.ls  = m.ls;
    e.fs  = m.fs;
    e.fc  = 16'(m.fc);
    return e;
  endfunction

  st_t  ma = '0, mb = '0;
  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model: advances on the same edge and queues the expected outputs.
  always @(posedge clk) begin
    ma = step(ma, CFG_A, rst_a, vif_a.i_en);
    mb = step(mb, CFG_B, rst_b, vif_b.i_en);
    q_a.push_back(outs(ma, CFG_A));
    q_b.push_back(outs(mb, CFG_B));
  end

  task automatic cmp_all(input string p, input exp_t e, input exp_t a);
    chk({p, "_cnt_x"},       32'(a.x),  32'(e.x));
    chk({p, "_cnt_y"},       32'(a.y),  32'(e.y));
    chk({p, "_active"},      32'(a.act), 32'(e.act));
    chk({p, "_hsync"},       32'(a.hs), 32'(e.hs));
    chk({p, "_vsync"},       32'(a.vs), 32'(e.vs));
    chk({p, "_de"},          32'(a.de), 32'(e.de));
    chk({p, "_line_start"},  32'(a.ls), 32'(e.ls));
    chk({p, "_frame_start"}, 32'(a.fs), 32'(e.fs));
    chk({p, "_frame_cnt"},   32'(a.fc), 32'(e.fc));
  endtask

  function automatic exp_t grab_a();
    return '{x:vif_a.o_cnt_x, y:vif_a.o_cnt_y, act:vif_a.o_active, hs:vif_a.o_hsync,
             vs:vif_a.o_vsync, de:vif_a.o_de, ls:vif_a.o_line_start,
             fs:vif_a.o_frame_start, fc:vif_a.o_frame_cnt};
  endfunction
  function automatic exp_t grab_b();
    return '{x:vif_b.o_cnt_x, y:vif_b.o_cnt_y, act:vif_b.o_active, hs:vif_b.o_hsync,
             vs:vif_b.o_vsync, de:vif_b.o_de, ls:vif_b.o_line_start,
             fs:vif_b.o_frame_start, fc:vif_b.o_frame_cnt};
  endfunction

  // Monitor: pops one expectation per DUT output cycle, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (q_a.size() > 0) cmp_all("a", q_a.pop_front(), grab_a());
    if (q_b.size() > 0) cmp_all("b", q_b.pop_front(), grab_b());
  end

  int de_cnt, hs_cnt, ls_cnt;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    vif_a.i_en = 1'b1; vif_b.i_en = 1'b1;
    @(negedge clk);
    chk("rst_a_x", 32'(vif_a.o_cnt_x), 0);
    chk("rst_a_active", 32'(vif_a.o_active), 1);
    chk("rst_a_hsync", 32'(vif_a.o_hsync), 0);
    chk("rst_a_vsync", 32'(vif_a.o_vsync), 0);
    chk("rst_a_de", 32'(vif_a.o_de), 0);
    chk("rst_a_ls", 32'(vif_a.o_line_start), 0);
    chk("rst_b_hsync", 32'(vif_b.o_hsync), 1);
    chk("rst_b_vsync", 32'(vif_b.o_vsync), 1);
    chk("rst_b_de", 32'(vif_b.o_de), 0);
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    de_cnt = 0; hs_cnt = 0; ls_cnt = 0;

    for (int k = 1; k <= 1750; k++) begin
      @(negedge clk);
      if (k <= 1650) begin
        de_cnt += int'(vif_a.o_de);
        hs_cnt += int'(vif_a.o_hsync);
      end
      if (k <= 1649) ls_cnt += int'(vif_a.o_line_start);
      case (k)
        1:    chk("a_de_k1", 32'(vif_a.o_de), 1);
        1280: chk("a_de_k1280", 32'(vif_a.o_de), 1);
        1281: chk("a_de_k1281", 32'(vif_a.o_de), 0);
        1390: chk("a_hs_k1390", 32'(vif_a.o_hsync), 0);
        1391: chk("a_hs_k1391", 32'(vif_a.o_hsync), 1);
        1430: chk("a_hs_k1430", 32'(vif_a.o_hsync), 1);
        1431: chk("a_hs_k1431", 32'(vif_a.o_hsync), 0);
        1649: chk("a_x_k1649", 32'(vif_a.o_cnt_x), 1649);
        1650: begin
          chk("a_x_wrap", 32'(vif_a.o_cnt_x), 0);
          chk("a_y_wrap", 32'(vif_a.o_cnt_y), 1);
          chk("a_ls_wrap", 32'(vif_a.o_line_start), 1);
          chk("a_fs_wrap", 32'(vif_a.o_frame_start), 0);
        end
        1651: chk("a_ls_k1651", 32'(vif_a.o_line_start), 0);
        default: ;
      endcase
      case (k)
        2:  chk("b_de_k2", 32'(vif_b.o_de), 0);
        3:  chk("b_de_k3", 32'(vif_b.o_de), 1);
        10: chk("b_de_k10", 32'(vif_b.o_de), 1);
        11: chk("b_de_k11", 32'(vif_b.o_de), 0);
        12: chk("b_hs_k12", 32'(vif_b.o_hsync), 1);
        13: chk("b_hs_k13", 32'(vif_b.o_hsync), 0);
        14: chk("b_hs_k14", 32'(vif_b.o_hsync), 0);
        15: chk("b_hs_k15", 32'(vif_b.o_hsync), 1);
        72: chk("b_vs_k72", 32'(vif_b.o_vsync), 1);
        73: chk("b_vs_k73", 32'(vif_b.o_vsync), 0);
        86: chk("b_vs_k86", 32'(vif_b.o_vsync), 0);
        87: chk("b_vs_k87", 32'(vif_b.o_vsync), 1);
        97: chk("b_fs_k97", 32'(vif_b.o_frame_start), 0);
        98: begin
          chk("b_x_fwrap", 32'(vif_b.o_cnt_x), 0);
          chk("b_y_fwrap", 32'(vif_b.o_cnt_y), 0);
          chk("b_fs_fwrap", 32'(vif_b.o_frame_start), 1);
          chk("b_fc_fwrap", 32'(vif_b.o_frame_cnt), 1);
        end
        99: chk("b_fs_k99", 32'(vif_b.o_frame_start), 0);
        default: ;
      endcase
    end
    chk("a_de_per_line", 32'(de_cnt), 1280);
    chk("a_hs_per_line", 32'(hs_cnt), 40);
    chk("a_ls_midline", 32'(ls_cnt), 0);
    chk("a_x_before_hold", 32'(vif_a.o_cnt_x), 100);

    vif_a.i_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("a_hold_x", 32'(vif_a.o_cnt_x), 100);
      chk("a_hold_active", 32'(vif_a.o_active), 1);
      chk("a_hold_ls", 32'(vif_a.o_line_start), 0);
    end
    vif_a.i_en = 1'b1;
    @(negedge clk);
    chk("a_resume_x", 32'(vif_a.o_cnt_x), 101);
    chk("a_resume_y", 32'(vif_a.o_cnt_y), 1);

    repeat (399) @(negedge clk);
    chk("a_pre_rst_x", 32'(vif_a.o_cnt_x), 500);
    chk("b_pre_rst_fc", 32'(vif_b.o_frame_cnt), 22);
    chk("b_pre_rst_x", 32'(vif_b.o_cnt_x), 1);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("a_mid_rst_x", 32'(vif_a.o_cnt_x), 0);
    chk("a_mid_rst_y", 32'(vif_a.o_cnt_y), 0);
    chk("a_mid_rst_de", 32'(vif_a.o_de), 0);
    chk("a_mid_rst_hs", 32'(vif_a.o_hsync), 0);
    chk("b_mid_rst_fc", 32'(vif_b.o_frame_cnt), 0);
    chk("b_mid_rst_hs", 32'(vif_b.o_hsync), 1);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    chk("a_post_rst_x", 32'(vif_a.o_cnt_x), 1);
    chk("b_post_rst_x", 32'(vif_b.o_cnt_x), 1);

    repeat (300) @(negedge clk);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Free-running raster timing source for the Tetris display path.
- Produces the 12-bit pixel coordinates (o_cnt_x, o_cnt_y) consumed by the frame/overlay pixel generators.
- Produces matching hsync/vsync/data-enable outputs. A configurable delay lines these up with the one-cycle-registered RGB outputs of those generators.
- Default timing is 1280x720@60, with a 74.25 MHz i_pixclk.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 110, horizontal front porch (clocks)
- H_SYNC, 40, hsync width (clocks)
- H_BP, 220, horizontal back porch (clocks)
- V_ACTIVE, 720, visible lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- H_POL, 1, hsync active level (1 = active-high)
- V_POL, 1, vsync active level
- SYNC_DLY, 1, extra register stages on o_hsync/o_vsync/o_de (range 0..7)

Ports:
- i_pixclk  in  1  pixel clock, all logic on rising edge
- i_reset_n  in  1  synchronous active-low reset
- i_en  in  1  raster advance enable; counters hold when 0
- o_cnt_x  out  12  current horizontal position, 0..H_TOTAL-1
- o_cnt_y  out  12  current line, 0..V_TOTAL-1
- o_active  out  1  1 when the current (x,y) is in the visible area; aligned with the counters
- o_hsync  out  1  horizontal sync, delayed SYNC_DLY cycles
- o_vsync  out  1  vertical sync, delayed SYNC_DLY cycles
- o_de  out  1  data enable, equal to o_active delayed SYNC_DLY cycles
- o_line_start  out  1  one-cycle strobe when x wraps to 0
- o_frame_start  out  1  one-cycle strobe when (x,y) wraps to (0,0)
- o_frame_cnt  out  16  completed-frame counter

Behaviour:
- Clock and reset: clock i_pixclk; reset i_reset_n, synchronous, active-low.
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1650).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (750).
  - Both totals must be <=4096. Elaboration fails otherwise, and also if SYNC_DLY>7.
- Reset values:
  - o_cnt_x=0, o_cnt_y=0, o_active=1 (position (0,0) is visible).
  - o_hsync=~H_POL, o_vsync=~V_POL, o_de=0.
  - o_line_start=0, o_frame_start=0, o_frame_cnt=0.
  - Every delay-pipeline stage is flushed to its inactive value.
- Counter update (each edge, not in reset, i_en=1):
  - If x<H_TOTAL-1: x+1.
  - Else x=0. Then if y<V_TOTAL-1, y+1; else y=0 and o_frame_cnt+1 (wraps 65535->0).
- i_en=0: x, y and o_frame_cnt hold. o_active keeps tracking the held position.
- Strobes:
  - o_line_start=1 only in the cycle after an update that wrapped x.
  - o_frame_start=1 only in the cycle after an update that wrapped both x and y.
  - Both are 0 in every other cycle, including held cycles.
  - The (0,0) position after reset is not strobed.
- Undelayed signals, computed from the registered (x,y):
  - active = (x<H_ACTIVE) && (y<V_ACTIVE).
  - hs = H_POL when H_ACTIVE+H_FP <= x <= H_ACTIVE+H_FP+H_SYNC-1, else ~H_POL.
  - vs = V_POL when V_ACTIVE+V_FP <= y <= V_ACTIVE+V_FP+V_SYNC-1, else ~V_POL. vs changes only together with a y change, i.e. at x=0.
- Delay pipeline:
  - hs, vs and active pass through SYNC_DLY registers that shift every clock, independent of i_en.
  - SYNC_DLY=0 drives o_hsync/o_vsync/o_de directly from hs/vs/active.
  - With the default SYNC_DLY=1, o_de rises exactly on the cycle the overlay generators present pixel (0,y).
- Reset mid-frame: all outputs return to reset values on the next edge. Counting restarts at (0,0) with o_frame_cnt=0.
- o_cnt_x and o_cnt_y are never delayed.

Test Plan:
- Reset then i_en=1 held: o_cnt_x counts 0..1649 and returns to 0. On the wrap, o_cnt_y goes 0->1 and o_line_start pulses for exactly 1 cycle. o_frame_start stays 0.
- Horizontal sync, defaults: with o_cnt_x=1390 visible, the raw hs is 1. o_hsync rises one cycle later (SYNC_DLY=1) and stays high 40 cycles, falling one cycle after o_cnt_x=1430 is visible. o_de is 1 for exactly 1280 cycles per visible line and 0 on lines 720..749.
- Frame wrap: at (1649,749) with i_en=1 -> next cycle (0,0), o_frame_start=1 for one cycle, o_frame_cnt=1. o_vsync is high for lines 725..729 only (5*1650 cycles).
- i_en toggling: drop i_en at x=100 for 7 cycles -> o_cnt_x holds at 100. o_active holds 1 and no strobes occur. Counting resumes at 101.
- Reduced parameters (H 8/2/2/2, V 4/1/1/1, H_POL=V_POL=0, SYNC_DLY=3): o_hsync is low for 2 cycles per 14-cycle line. Sync and o_de edges lag the raw hs/active by exactly 3 cycles.
- Mid-frame reset at (500,300): drive i_reset_n=0 for 1 cycle -> next edge (0,0), o_frame_cnt=0, o_de=0, o_hsync=~H_POL. Normal counting resumes the cycle after reset is released.
